fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of instruction entries; legal values are 2, 4 and 8.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address loaded at reset.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-low (0 = reset asserted).
REQ-005 redirect  input  1  SHALL request a flush and refetch from redirect_pc (taken branch or jump).
REQ-006 redirect_pc  input  32  SHALL give the new fetch address, sampled when redirect=1.
REQ-007 stall  input  1  SHALL hold the head entry when 1 (hazard stall from the decode stage).
REQ-008 out_valid  output  1  SHALL be 1 when out_instr/out_pc4 hold a real instruction.
REQ-009 out_instr  output  32  SHALL carry the head instruction word.
REQ-010 out_pc4  output  32  SHALL carry the head instruction's address + 4.
REQ-011 mem_req  output  1  SHALL signal a pending instruction-memory read.
REQ-012 mem_addr  output  32  SHALL carry the read address, word aligned.
REQ-013 mem_ack  input  1  SHALL mark the cycle in which mem_rdata is valid.
REQ-014 mem_rdata  input  32  SHALL carry the instruction word returned by memory.

Function
REQ-015 The FSM SHALL have states IDLE, REQ and DRAIN; mem_req SHALL be 1 in REQ and DRAIN and 0 in IDLE.
REQ-016 IDLE SHALL go to REQ when count < DEPTH and redirect=0; mem_addr SHALL then equal fetch_pc.
REQ-017 In REQ and DRAIN, mem_req and mem_addr SHALL stay stable until the cycle in which mem_ack=1.
REQ-018 At REQ with mem_ack=1 and redirect=0, the block SHALL push {mem_rdata, mem_addr+4} at the tail and set fetch_pc to fetch_pc+4.
REQ-019 After the push in REQ-018, the FSM SHALL stay in REQ with the new address when (count after push and pop) < DEPTH, and SHALL otherwise go to IDLE.
REQ-020 A pop SHALL occur on every edge where out_valid=1 and stall=0; the head then advances one entry.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged and SHALL keep FIFO order.
REQ-022 A request SHALL issue only when count < DEPTH, which reserves a slot; count SHALL never exceed DEPTH and a push SHALL never be dropped.
REQ-023 At most one memory request SHALL be outstanding at any time.
REQ-024 When redirect=1, the next edge SHALL clear count and set fetch_pc to redirect_pc; out_valid SHALL be 0 in the following cycle.
REQ-025 If redirect=1 in REQ with mem_ack=0, the FSM SHALL go to DRAIN; in DRAIN, mem_ack SHALL discard the data and move the FSM to IDLE.
REQ-026 If redirect=1 in the same cycle as mem_ack=1, the returned word SHALL be discarded and the FSM SHALL go to IDLE.
REQ-027 A redirect arriving while the FSM is already in DRAIN SHALL update fetch_pc only; the FSM SHALL stay in DRAIN.
REQ-028 redirect SHALL take priority over stall and over a pop in the same cycle.
REQ-029 When out_valid=0, out_instr SHALL be 32'h0 (NOP bubble) and out_pc4 SHALL be 32'h0.
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-031 mem_addr[1:0] SHALL always be 2'b00; redirect_pc[1:0] SHALL be ignored (forced to 0).

Reset
REQ-032 While reset=0, the block SHALL hold: state IDLE, count 0, fetch_pc = RESET_PC, and outputs out_valid, out_instr, out_pc4, mem_req and mem_addr all 0.
REQ-033 reset assertion SHALL take effect immediately, without a clock edge, even mid-request; any later mem_ack for the abandoned request SHALL be ignored.
REQ-034 mem_req SHALL first assert in the cycle after the first rising edge with reset=1.

Verification
REQ-035 Reset release with memory acking 1 cycle after each request, words 0x11, 0x22, 0x33 and stall=0 -> outputs in order: (0x11, pc4 0x4), (0x22, 0x8), (0x33, 0xC).
REQ-036 stall=1 held for 10 cycles, DEPTH=4 -> exactly 4 entries accepted, mem_req goes low, head stays 0x11; on stall release, 4 pops occur in order with no loss.
REQ-037 redirect to 0x100 while a request for 0x8 is pending and ack arrives 3 cycles later -> the 0x8 data is dropped, the next mem_addr is 0x100, and the first out_pc4 is 0x104.
REQ-038 redirect to 0x40 in the same cycle as mem_ack -> the acked word is never output, the queue is empty next cycle, and the next mem_addr is 0x40.
REQ-039 redirect to 0xFFFF_FFFC -> mem_addr sequence is 0xFFFF_FFFC then 0x0000_0000; out_pc4 values are 0x0 then 0x4.
REQ-040 reset=0 pulsed mid-request with 3 entries queued -> out_valid drops without a clock edge, and fetch restarts at RESET_PC after reset release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one word-aligned memory read at a time and buffers
// returned instructions with their pc+4 in a small FIFO, with flush-on-redirect.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc4,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned      PTR_W   = $clog2(DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [31:0]      ALIGN_M = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       instr_q [DEPTH];
   logic [31:0]       instr_d [DEPTH];
   logic [31:0]       pc4_q   [DEPTH];
   logic [31:0]       pc4_d   [DEPTH];
   logic              push_s;
   logic              pop_s;
   logic [CNT_W-1:0]  count_after_s;

   // Next-state, fetch address and queue bookkeeping; redirect overrides everything else.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      head_d        = head_q;
      tail_d        = tail_q;
      fetch_pc_d    = fetch_pc_q;
      mem_addr_d    = mem_addr_q;
      instr_d       = instr_q;
      pc4_d         = pc4_q;
      push_s        = 1'b0;
      pop_s         = (count_q != {CNT_W{1'b0}}) && !stall && !redirect;
      count_after_s = count_q + CNT_W'(1) - CNT_W'(pop_s);

      case (state_q)
         IDLE: begin
            if (!redirect && (count_q < DEPTH_C)) begin
               state_d    = REQ;
               mem_addr_d = fetch_pc_q;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (redirect) begin
               state_d = mem_ack ? IDLE : DRAIN;
            end else if (mem_ack) begin
               push_s     = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (count_after_s < DEPTH_C) begin
                  state_d    = REQ;
                  mem_addr_d = fetch_pc_q + 32'd4;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = REQ;
            end
         end
         // The outstanding read must complete before a new one may issue.
         DRAIN: begin
            if (mem_ack) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect) begin
         count_d    = {CNT_W{1'b0}};
         head_d     = {PTR_W{1'b0}};
         tail_d     = {PTR_W{1'b0}};
         fetch_pc_d = redirect_pc & ALIGN_M;
      end else begin
         if (push_s) begin
            instr_d[tail_q] = mem_rdata;
            pc4_d[tail_q]   = mem_addr_q + 32'd4;
            tail_d          = tail_q + PTR_W'(1);
         end else begin
            tail_d = tail_q;
         end
         if (pop_s) begin
            head_d = head_q + PTR_W'(1);
         end else begin
            head_d = head_q;
         end
         count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      end
   end

   // State and storage registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= {CNT_W{1'b0}};
         head_q     <= {PTR_W{1'b0}};
         tail_q     <= {PTR_W{1'b0}};
         fetch_pc_q <= RESET_PC & ALIGN_M;
         mem_addr_q <= 32'h0000_0000;
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_q[i] <= 32'h0000_0000;
            pc4_q[i]   <= 32'h0000_0000;
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
      end
   end

   // Outputs are decoded purely from flops; empty queue presents a zero bubble.
   always_comb begin
      out_valid = (count_q != {CNT_W{1'b0}});
      mem_req   = (state_q != IDLE);
      mem_addr  = mem_addr_q;
      if (out_valid) begin
         out_instr = instr_q[head_q];
         out_pc4   = pc4_q[head_q];
      end else begin
         out_instr = 32'h0000_0000;
         out_pc4   = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, in-order fetch, stall back-pressure,
// redirect flushes (pending, same-cycle, address wrap, during drain) and async reset.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc4;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int   checks   = 0;
   int   failures = 0;
   logic auto_ack;
   int   lat;
   int   age;
   logic req_seen;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc4     (out_pc4),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   // Memory image used by the automatic responder: 0x0->0x11, 0x4->0x22, 0x8->0x33 ...
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h0000_0011 * ((a >> 2) + 32'd1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; optionally answer the current request after lat waiting cycles.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (auto_ack) begin
         if (mem_req) begin
            if (req_seen && !mem_ack) age = age + 1;
            else age = 0;
            req_seen  = 1'b1;
            mem_ack   = (age >= lat);
            mem_rdata = mem_ack ? word_at(mem_addr) : 32'h0000_0000;
         end else begin
            req_seen = 1'b0;
            mem_ack  = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0000_0000;
      req_seen  = 1'b0;
      age       = 0;
      reset     = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         cyc();
      end
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_instr"}, out_instr, instr);
      chk({tag, "_pc4"}, out_pc4, pc4);
      cyc();
   endtask

   initial begin
      reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
      mem_ack = 1'b0; mem_rdata = 32'h0; auto_ack = 1'b0; lat = 1; age = 0; req_seen = 1'b0;

      // Reset state before any clock edge
      #2;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc4", out_pc4, 32'h0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      cyc();
      cyc();
      chk("rst_req_held", {31'd0, mem_req}, 32'd0);
      reset = 1'b1;
      chk("rel_req_before_edge", {31'd0, mem_req}, 32'd0);
      auto_ack = 1'b1;
      cyc();
      chk("first_req", {31'd0, mem_req}, 32'd1);
      chk("first_addr", mem_addr, 32'h0);

      // In-order fetch, 1-cycle memory latency
      expect_out("seq0", 32'h11, 32'h4);
      expect_out("seq1", 32'h22, 32'h8);
      expect_out("seq2", 32'h33, 32'hC);

      // Stall fills the queue to DEPTH, then releases with no loss
      stall = 1'b1;
      do_reset();
      for (int i = 0; i < 12; i++) cyc();
      chk("full_req_low", {31'd0, mem_req}, 32'd0);
      chk("full_valid", {31'd0, out_valid}, 32'd1);
      chk("full_head", out_instr, 32'h11);
      chk("full_pc4", out_pc4, 32'h4);
      stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("drain_valid", {31'd0, out_valid}, 32'd1);
         chk("drain_instr", out_instr, word_at(32'(4 * k)));
         chk("drain_pc4", out_pc4, 32'(4 * k + 4));
         cyc();
      end
      expect_out("refill", 32'h55, 32'h14);

      // Redirect while a request for 0x8 is pending
      auto_ack = 1'b0;
      do_reset();
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'h11;
      cyc();
      mem_rdata = 32'h22;
      cyc();
      chk("pend_instr", out_instr, 32'h22);
      chk("pend_pc4", out_pc4, 32'h8);
      chk("pend_addr", mem_addr, 32'h8);
      mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      cyc();
      redirect = 1'b0;
      chk("rd_flush_valid", {31'd0, out_valid}, 32'd0);
      chk("rd_drain_req", {31'd0, mem_req}, 32'd1);
      chk("rd_drain_addr", mem_addr, 32'h8);
      cyc();
      chk("rd_drain_addr2", mem_addr, 32'h8);
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_0008;
      cyc();
      mem_ack = 1'b0;
      chk("rd_dropped_valid", {31'd0, out_valid}, 32'd0);
      chk("rd_idle_req", {31'd0, mem_req}, 32'd0);
      cyc();
      chk("rd_new_req", {31'd0, mem_req}, 32'd1);
      chk("rd_new_addr", mem_addr, 32'h100);
      chk("rd_new_valid", {31'd0, out_valid}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hABC;
      cyc();
      chk("rd_out_instr", out_instr, 32'hABC);
      chk("rd_out_pc4", out_pc4, 32'h104);

      // Redirect in the same cycle as mem_ack
      mem_rdata = 32'hBAD; redirect = 1'b1; redirect_pc = 32'h40;
      cyc();
      redirect = 1'b0; mem_ack = 1'b0;
      chk("same_valid", {31'd0, out_valid}, 32'd0);
      chk("same_req", {31'd0, mem_req}, 32'd0);
      cyc();
      chk("same_addr", mem_addr, 32'h40);
      chk("same_valid2", {31'd0, out_valid}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h77;
      cyc();
      chk("same_out_instr", out_instr, 32'h77);
      chk("same_out_pc4", out_pc4, 32'h44);

      // Redirect to top of memory, low bits ignored, address wraps
      mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      cyc();
      redirect = 1'b0;
      chk("wrap_flush", {31'd0, out_valid}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h5;
      cyc();
      mem_ack = 1'b0;
      chk("wrap_idle", {31'd0, mem_req}, 32'd0);
      cyc();
      chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
      mem_ack = 1'b1; mem_rdata = 32'hA1;
      cyc();
      chk("wrap_pc4_0", out_pc4, 32'h0);
      chk("wrap_instr0", out_instr, 32'hA1);
      chk("wrap_addr1", mem_addr, 32'h0);
      mem_rdata = 32'hA2;
      cyc();
      chk("wrap_pc4_1", out_pc4, 32'h4);
      chk("wrap_instr1", out_instr, 32'hA2);

      // Second redirect while already draining
      mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
      cyc();
      redirect_pc = 32'h500;
      chk("dd_req", {31'd0, mem_req}, 32'd1);
      cyc();
      redirect = 1'b0;
      chk("dd_still_drain", {31'd0, mem_req}, 32'd1);
      chk("dd_addr", mem_addr, 32'h4);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("dd_idle", {31'd0, mem_req}, 32'd0);
      cyc();
      chk("dd_new_addr", mem_addr, 32'h500);

      // Asynchronous reset mid-request with 3 entries queued
      auto_ack = 1'b1; stall = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) cyc();
      chk("ar_valid_pre", {31'd0, out_valid}, 32'd1);
      chk("ar_req_pre", {31'd0, mem_req}, 32'd1);
      chk("ar_addr_pre", mem_addr, 32'hC);
      auto_ack = 1'b0; mem_ack = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_req", {31'd0, mem_req}, 32'd0);
      chk("ar_addr", mem_addr, 32'h0);
      chk("ar_instr", out_instr, 32'h0);
      chk("ar_pc4", out_pc4, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF; stall = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("ar_late_ack_ignored", {31'd0, out_valid}, 32'd0);
      chk("ar_restart_req", {31'd0, mem_req}, 32'd1);
      chk("ar_restart_addr", mem_addr, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h99;
      cyc();
      mem_ack = 1'b0;
      chk("ar_out_instr", out_instr, 32'h99);
      chk("ar_out_pc4", out_pc4, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
